// File: rtl/proximity_alert_ctrl_pkg.sv
// Shared types for the proximity alert controller: buzzer level codes and FSM states.
package proximity_alert_ctrl_pkg;

  // Level codes match the buzzer's 2-bit intensity input directly.
  typedef enum logic [1:0] {
    LvlDis = 2'b00,
    LvlLow = 2'b01,
    LvlMed = 2'b10,
    LvlHi  = 2'b11
  } level_e;

  typedef enum logic [1:0] {
    StDisarmed = 2'b00,
    StWait     = 2'b01,
    StTrack    = 2'b10,
    StStale    = 2'b11
  } state_e;

  // Confirmation counter width; covers CONFIRM_UP/CONFIRM_DN up to 15.
  localparam int unsigned CntW = 4;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/proximity_alert_ctrl_range_classifier.sv
// Combinational distance-to-level classifier with hysteresis on the way down.
module range_classifier
  import proximity_alert_ctrl_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned TH_HI  = 20,
  parameter int unsigned TH_MED = 50,
  parameter int unsigned TH_LOW = 100,
  parameter int unsigned HYST   = 5
) (
  input  logic [DW-1:0] dist_i,
  input  level_e        level_i,
  output level_e        raw_o
);

  // One extra bit so threshold + HYST never wraps.
  localparam int unsigned W1 = DW + 1;

  localparam logic [W1-1:0] ThHi   = W1'(TH_HI);
  localparam logic [W1-1:0] ThMed  = W1'(TH_MED);
  localparam logic [W1-1:0] ThLow  = W1'(TH_LOW);
  localparam logic [W1-1:0] ThHiH  = W1'(TH_HI + HYST);
  localparam logic [W1-1:0] ThMedH = W1'(TH_MED + HYST);
  localparam logic [W1-1:0] ThLowH = W1'(TH_LOW + HYST);

  logic [W1-1:0] dist_x;
  logic [W1-1:0] drop_thr;
  level_e        cls;

  assign dist_x = {1'b0, dist_i};

  always_comb begin
    cls = LvlDis;
    if (dist_x < ThLow) cls = LvlLow;
    if (dist_x < ThMed) cls = LvlMed;
    if (dist_x < ThHi)  cls = LvlHi;
  end

  always_comb begin
    drop_thr = '0;
    unique case (level_i)
      LvlHi:   drop_thr = ThHiH;
      LvlMed:  drop_thr = ThMedH;
      LvlLow:  drop_thr = ThLowH;
      LvlDis:  drop_thr = '0;
      default: drop_thr = '0;
    endcase
  end

  always_comb begin
    raw_o = level_i;
    if (cls > level_i) begin
      raw_o = cls;
    end else if ((cls < level_i) && (dist_x >= drop_thr)) begin
      raw_o = cls;
    end
  end

endmodule

// File: rtl/proximity_alert_ctrl.sv
// Buzzer alert sequencer: confirms classified range samples into a committed level and
// handles arm/mute control and stale-data timeout.
module proximity_alert_ctrl
  import proximity_alert_ctrl_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned TH_HI      = 20,
  parameter int unsigned TH_MED     = 50,
  parameter int unsigned TH_LOW     = 100,
  parameter int unsigned HYST       = 5,
  parameter int unsigned CONFIRM_UP = 1,
  parameter int unsigned CONFIRM_DN = 3,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned TW         = 20
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] dist_i,
  input  logic          dist_valid_i,
  input  logic          arm_i,
  input  logic          mute_i,
  output logic          buzz_state_o,
  output logic [1:0]    buzz_en_o,
  output logic          level_chg_o,
  output logic          stale_o
);

  localparam logic [CntW-1:0] ConfUp = CntW'(CONFIRM_UP);
  localparam logic [CntW-1:0] ConfDn = CntW'(CONFIRM_DN);
  localparam logic [TW-1:0]   TmoLast = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  level_e          level_q, level_d;
  level_e          cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            stale_q, stale_d;
  logic            chg_q, chg_d;
  logic            buzz_q, buzz_d;

  logic            accept;
  level_e          raw;

  // Result of processing the current sample against the committed level.
  level_e          trk_level;
  level_e          trk_cand;
  logic [CntW-1:0] trk_cnt;
  logic [CntW-1:0] cnt_nxt;
  logic [CntW-1:0] need;
  logic            trk_chg;

  // A zero distance is an echo error and is treated as no sample at all.
  assign accept = dist_valid_i && (dist_i != '0);

  range_classifier #(
    .DW     (DW),
    .TH_HI  (TH_HI),
    .TH_MED (TH_MED),
    .TH_LOW (TH_LOW),
    .HYST   (HYST)
  ) u_range_classifier (
    .dist_i  (dist_i),
    .level_i (level_q),
    .raw_o   (raw)
  );

  always_comb begin
    trk_level = level_q;
    trk_cand  = cand_q;
    trk_cnt   = cnt_q;
    trk_chg   = 1'b0;
    cnt_nxt   = '0;
    need      = ConfDn;
    if (raw == level_q) begin
      trk_cand = level_q;
      trk_cnt  = '0;
    end else begin
      cnt_nxt  = (raw == cand_q) ? sat_inc(cnt_q) : CntW'(1);
      need     = (raw > level_q) ? ConfUp : ConfDn;
      trk_cand = raw;
      trk_cnt  = cnt_nxt;
      if (cnt_nxt >= need) begin
        trk_level = raw;
        trk_cnt   = '0;
        trk_chg   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    stale_d = stale_q;
    chg_d   = 1'b0;

    if (!arm_i) begin
      // Disarm wins over any sample or timeout in the same cycle.
      state_d = StDisarmed;
      level_d = LvlDis;
      cand_d  = LvlDis;
      cnt_d   = '0;
      tmo_d   = '0;
      stale_d = 1'b0;
      chg_d   = (level_q != LvlDis);
    end else begin
      unique case (state_q)
        StDisarmed: begin
          state_d = StWait;
          tmo_d   = '0;
        end
        StWait, StTrack: begin
          if (accept) begin
            state_d = StTrack;
            level_d = trk_level;
            cand_d  = trk_cand;
            cnt_d   = trk_cnt;
            chg_d   = trk_chg;
            tmo_d   = '0;
          end else if (tmo_q >= TmoLast) begin
            state_d = StStale;
            level_d = LvlDis;
            cand_d  = LvlDis;
            cnt_d   = '0;
            tmo_d   = '0;
            stale_d = 1'b1;
            chg_d   = (level_q != LvlDis);
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        StStale: begin
          if (accept) begin
            state_d = StTrack;
            stale_d = 1'b0;
            level_d = trk_level;
            cand_d  = trk_cand;
            cnt_d   = trk_cnt;
            chg_d   = trk_chg;
            tmo_d   = '0;
          end
        end
        default: state_d = StDisarmed;
      endcase
    end

    buzz_d = arm_i && !mute_i && !stale_d && (level_d != LvlDis);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StDisarmed;
      level_q <= LvlDis;
      cand_q  <= LvlDis;
      cnt_q   <= '0;
      tmo_q   <= '0;
      stale_q <= 1'b0;
      chg_q   <= 1'b0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      stale_q <= stale_d;
      chg_q   <= chg_d;
      buzz_q  <= buzz_d;
    end
  end

  assign buzz_en_o    = level_q;
  assign buzz_state_o = buzz_q;
  assign level_chg_o  = chg_q;
  assign stale_o      = stale_q;

endmodule

// File: tb/tb_proximity_alert_ctrl.sv
// Directed plus randomized bench for proximity_alert_ctrl against a behavioural model.
module tb_proximity_alert_ctrl;

  localparam int unsigned TimeoutCyc = 100;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] dist_i = '0;
  logic        dist_valid_i = 1'b0;
  logic        arm_i = 1'b0;
  logic        mute_i = 1'b0;
  logic        buzz_state_o;
  logic [1:0]  buzz_en_o;
  logic        level_chg_o;
  logic        stale_o;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Behavioural model state.
  bit m_on;
  int m_level, m_cand, m_cnt, m_idle;
  bit m_stale, m_chg, m_buzz;

  proximity_alert_ctrl #(
    .TIMEOUT (TimeoutCyc)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dist_i       (dist_i),
    .dist_valid_i (dist_valid_i),
    .arm_i        (arm_i),
    .mute_i       (mute_i),
    .buzz_state_o (buzz_state_o),
    .buzz_en_o    (buzz_en_o),
    .level_chg_o  (level_chg_o),
    .stale_o      (stale_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int zone(input int d);
    if (d < 20) return 3;
    if (d < 50) return 2;
    if (d < 100) return 1;
    return 0;
  endfunction

  function automatic int drop_dist(input int l);
    int thr [4] = '{0, 100, 50, 20};
    return thr[l] + 5;
  endfunction

  task automatic model_reset();
    m_on = 0; m_level = 0; m_cand = 0; m_cnt = 0; m_idle = 0;
    m_stale = 0; m_chg = 0; m_buzz = 0;
  endtask

  task automatic model_sample(input int d);
    int z, raw, need;
    z = zone(d);
    raw = m_level;
    if (z > m_level || (z < m_level && d >= drop_dist(m_level))) raw = z;
    if (raw == m_level) begin
      m_cnt = 0;
      m_cand = m_level;
    end else begin
      m_cnt = (raw == m_cand) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
      m_cand = raw;
      need = (raw > m_level) ? 1 : 3;
      if (m_cnt >= need) begin
        m_level = raw;
        m_cnt = 0;
        m_chg = 1;
      end
    end
  endtask

  task automatic model_step(input bit a, input bit m, input bit v, input int d);
    int prev;
    prev = m_level;
    m_chg = 0;
    if (!a) begin
      m_on = 0; m_level = 0; m_cand = 0; m_cnt = 0; m_idle = 0; m_stale = 0;
      m_chg = (prev != 0);
    end else if (!m_on) begin
      m_on = 1;
      m_idle = 0;
    end else if (v && d != 0) begin
      m_stale = 0;
      m_idle = 0;
      model_sample(d);
    end else if (!m_stale) begin
      m_idle++;
      if (m_idle >= TimeoutCyc) begin
        m_stale = 1; m_level = 0; m_cand = 0; m_cnt = 0; m_idle = 0;
        m_chg = (prev != 0);
      end
    end
    m_buzz = a && !m && !m_stale && (m_level != 0);
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".buzz_en"}, buzz_en_o, 2'(m_level));
    check({tag, ".buzz_state"}, {1'b0, buzz_state_o}, {1'b0, m_buzz});
    check({tag, ".level_chg"}, {1'b0, level_chg_o}, {1'b0, m_chg});
    check({tag, ".stale"}, {1'b0, stale_o}, {1'b0, m_stale});
  endtask

  task automatic tick(input bit a, input bit m, input bit v, input int d, input string tag);
    @(negedge clk_i);
    arm_i = a; mute_i = m; dist_valid_i = v; dist_i = 16'(d);
    @(posedge clk_i);
    model_step(a, m, v, d);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, tag);
  endtask

  initial begin
    int d, r;
    bit v, a, m;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Arm, far sample: nothing alerts.
    tick(1, 0, 0, 0, "arm");
    tick(1, 0, 1, 150, "far150");
    check("far150.en_const", buzz_en_o, 2'b00);

    // Jump straight to high.
    tick(1, 0, 1, 15, "near15");
    check("near15.en_const", buzz_en_o, 2'b11);
    check("near15.chg_const", {1'b0, level_chg_o}, 2'b01);
    check("near15.buzz_const", {1'b0, buzz_state_o}, 2'b01);
    tick(1, 0, 0, 0, "near15.after");

    // Inside hysteresis band holds level 3.
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 22, "hyst22");
    check("hyst22.en_const", buzz_en_o, 2'b11);
    tick(1, 0, 1, 30, "drop30a");
    tick(1, 0, 1, 30, "drop30b");
    check("drop30b.en_const", buzz_en_o, 2'b11);
    tick(1, 0, 1, 30, "drop30c");
    check("drop30c.en_const", buzz_en_o, 2'b10);
    check("drop30c.chg_const", {1'b0, level_chg_o}, 2'b01);

    // Interrupted confirmation restarts the count.
    tick(1, 0, 1, 120, "rst120a");
    tick(1, 0, 1, 120, "rst120b");
    tick(1, 0, 1, 40, "rst40");
    tick(1, 0, 1, 120, "rst120c");
    check("rst120c.en_const", buzz_en_o, 2'b10);
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 120, "fall120");
    check("fall120.en_const", buzz_en_o, 2'b00);

    // Echo errors are ignored; stale after TIMEOUT idle cycles.
    tick(1, 0, 1, 60, "lvl60");
    check("lvl60.en_const", buzz_en_o, 2'b01);
    idle(TimeoutCyc - 2, "idle");
    tick(1, 0, 1, 0, "echo_err");
    check("pre_stale.const", {1'b0, stale_o}, 2'b00);
    tick(1, 0, 0, 0, "stale_hit");
    check("stale.const", {1'b0, stale_o}, 2'b01);
    check("stale.chg_const", {1'b0, level_chg_o}, 2'b01);
    check("stale.en_const", buzz_en_o, 2'b00);
    tick(1, 0, 1, 60, "unstale60");
    check("unstale.en_const", buzz_en_o, 2'b01);
    check("unstale.stale_const", {1'b0, stale_o}, 2'b00);

    // Mute silences but keeps level.
    tick(1, 0, 1, 10, "hi10");
    tick(1, 1, 0, 0, "mute");
    check("mute.buzz_const", {1'b0, buzz_state_o}, 2'b00);
    check("mute.en_const", buzz_en_o, 2'b11);

    // Async reset mid-TRACK clears outputs without a clock edge.
    tick(1, 0, 0, 0, "unmute");
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Disarm beats a simultaneous sample.
    tick(1, 0, 0, 0, "rearm");
    tick(1, 0, 1, 10, "rearm_hi");
    tick(0, 0, 1, 10, "disarm");
    check("disarm.en_const", buzz_en_o, 2'b00);
    check("disarm.chg_const", {1'b0, level_chg_o}, 2'b01);

    // Randomized phase: alternating busy and sparse sample rates.
    for (int i = 0; i < 3000; i++) begin
      v = (i % 600 < 300) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 1);
      a = ($urandom_range(0, 199) != 0);
      m = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 19);
      if (r == 0) d = 0;
      else if (r < 3) d = $urandom_range(100, 65535);
      else d = $urandom_range(1, 130);
      tick(a, m, v, d, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
